// File: rtl/instmem_loader_if.sv
// Loader bus bundle: incoming byte stream plus the instruction-memory write port.
// Handshakes: a byte moves on a rising edge with byte_valid && byte_ready; a write completes on a rising edge with mem_we && mem_ack.
interface instmem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;

  modport master (
    input  byte_valid, byte_data, mem_ack,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output byte_valid, byte_data, mem_ack,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instmem_loader.sv
// Boot loader: receives a length/data/checksum frame, writes big-endian words into
// instruction memory and holds the CPU until the whole program has been verified.
module instmem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   instmem_loader_if.master      bus,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error,
   output logic [2:0]            stateDbg
);

   typedef enum logic [2:0] {
      HDR   = 3'd0,
      DATA  = 3'd1,
      WRITE = 3'd2,
      CSUM  = 3'd3,
      DONE  = 3'd4,
      ERR   = 3'd5
   } loaderState_t;

   localparam logic [7:0]  MaxWords  = 8'(MAX_WORDS);
   localparam logic [31:0] AlignBase = {BASE_ADDR[31:2], 2'b00};

   loaderState_t state;
   logic [7:0]   nWords;
   logic [7:0]   wordIdx;
   logic [1:0]   byteCnt;
   logic [23:0]  shiftReg;
   logic [7:0]   csum;
   logic         xfer;
   logic [31:0]  wordAddr;
   logic         lastWord;

   assign xfer     = bus.byte_valid && bus.byte_ready;
   assign wordAddr = AlignBase + {22'd0, wordIdx, 2'b00};
   assign lastWord = ({1'b0, wordIdx} + 9'd1) == {1'b0, nWords};
   assign stateDbg = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= HDR;
         nWords         <= 8'd0;
         wordIdx        <= 8'd0;
         byteCnt        <= 2'd0;
         shiftReg       <= 24'd0;
         csum           <= 8'd0;
         bus.byte_ready <= 1'b0;
         bus.mem_we     <= 1'b0;
         bus.mem_addr   <= AlignBase;
         bus.mem_wdata  <= 32'd0;
         cpu_hold       <= 1'b1;
         done           <= 1'b0;
         error          <= 1'b0;
      end else begin
         case (state)
            HDR: begin
               bus.byte_ready <= 1'b1;
               if (xfer) begin
                  nWords  <= bus.byte_data;
                  wordIdx <= 8'd0;
                  byteCnt <= 2'd0;
                  if (bus.byte_data > MaxWords) begin
                     state          <= ERR;
                     bus.byte_ready <= 1'b0;
                     error          <= 1'b1;
                  end else if (bus.byte_data == 8'd0) begin
                     state <= CSUM;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (xfer) begin
                  shiftReg <= {shiftReg[15:0], bus.byte_data};
                  csum     <= csum ^ bus.byte_data;
                  byteCnt  <= byteCnt + 2'd1;
                  if (byteCnt == 2'd3) begin
                     // Word is complete: present it and stop the stream until the memory acks.
                     state          <= WRITE;
                     bus.byte_ready <= 1'b0;
                     bus.mem_we     <= 1'b1;
                     bus.mem_addr   <= wordAddr;
                     bus.mem_wdata  <= {shiftReg, bus.byte_data};
                  end
               end
            end
            WRITE: begin
               if (bus.mem_ack) begin
                  bus.mem_we     <= 1'b0;
                  bus.byte_ready <= 1'b1;
                  wordIdx        <= wordIdx + 8'd1;
                  state          <= lastWord ? CSUM : DATA;
               end
            end
            CSUM: begin
               if (xfer) begin
                  bus.byte_ready <= 1'b0;
                  if (bus.byte_data == csum) begin
                     state    <= DONE;
                     cpu_hold <= 1'b0;
                     done     <= 1'b1;
                  end else begin
                     state <= ERR;
                     error <= 1'b1;
                  end
               end
            end
            DONE: begin
               bus.byte_ready <= 1'b0;
               bus.mem_we     <= 1'b0;
            end
            ERR: begin
               bus.byte_ready <= 1'b0;
               bus.mem_we     <= 1'b0;
            end
            default: begin
               state          <= ERR;
               bus.byte_ready <= 1'b0;
               bus.mem_we     <= 1'b0;
               cpu_hold       <= 1'b1;
               done           <= 1'b0;
               error          <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/instmem_loader.md
INSTMEM_LOADER -- requirements
Module: instmem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first instruction word written.
REQ-002 Parameter MAX_WORDS, default 64: largest accepted program length in words (range 1..255).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 byte_valid  input  1  loader stream byte present.
REQ-006 byte_data  input  8  loader stream byte.
REQ-007 byte_ready  output  1  loader accepts byte_data this cycle.
REQ-008 mem_we  output  1  instruction-memory write request.
REQ-009 mem_addr  output  32  word-aligned byte address of the write.
REQ-010 mem_wdata  output  32  instruction word to write.
REQ-011 mem_ack  input  1  instruction memory has completed the write.
REQ-012 cpu_hold  output  1  keeps the datapath PC frozen while high.
REQ-013 done  output  1  program loaded and checksum correct.
REQ-014 error  output  1  load aborted: length out of range or checksum mismatch.

Function
REQ-015 A byte SHALL be transferred on a rising edge where byte_valid and byte_ready are both 1; no other edge transfers a byte.
REQ-016 Frame format SHALL be: header byte N (word count), then 4*N data bytes, then one checksum byte.
REQ-017 Words SHALL be assembled big-endian: first data byte -> mem_wdata[31:24], fourth -> [7:0].
REQ-018 Checksum SHALL be the XOR of all 4*N data bytes (header excluded). With N=0 the expected value is 8'h00.
REQ-019 States SHALL be HDR, DATA, WRITE, CSUM, DONE, ERR.
REQ-020 byte_ready SHALL be 1 only in HDR, DATA and CSUM.
REQ-021 HDR: on header transfer, N > MAX_WORDS -> ERR; N = 0 -> CSUM; otherwise -> DATA with word index k=0.
REQ-022 DATA: on the 4th byte transfer of a word -> WRITE on the next edge.
REQ-023 WRITE: mem_we=1, mem_addr=BASE_ADDR+4*k, mem_wdata=assembled word, all held stable until the edge where mem_ack=1.
REQ-024 WRITE: on that edge k increments, and the next state is CSUM if k+1 = N, otherwise DATA.
REQ-025 mem_ack SHALL be ignored outside WRITE.
REQ-026 mem_we SHALL be 0 outside WRITE, so at most one write occurs per word.
REQ-027 CSUM: on the checksum byte transfer, match -> DONE; mismatch -> ERR.
REQ-028 DONE: cpu_hold=0 and done=1 from the first cycle in DONE. Terminal until reset; bytes are not accepted.
REQ-029 ERR: cpu_hold=1 and error=1. Terminal until reset; bytes are not accepted and no writes occur.
REQ-030 cpu_hold SHALL be 1 in every state except DONE; done and error are never 1 together.
REQ-031 Address arithmetic is 32-bit modulo 2^32.
REQ-032 mem_addr[1:0] is always 2'b00.
REQ-033 Outputs SHALL be registered or decoded from registered state only; no combinational path from inputs to outputs.

Reset
REQ-034 rst_n=0 SHALL immediately force: state HDR, k=0, checksum=0, byte counter=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, byte_ready=0, cpu_hold=1, done=0, error=0.
REQ-035 While rst_n=0, byte_ready SHALL stay 0.
REQ-036 byte_ready SHALL become 1 on the first rising edge after rst_n deasserts.
REQ-037 Reset asserted mid-frame (including during WRITE with mem_ack pending) SHALL drop mem_we at once.
REQ-038 After that reset the loader SHALL restart at HDR with no partial word retained.

Verification
REQ-039 Stream 02, 24 08 00 05, 00 00 00 0C, cs=0x25, mem_ack=1 each write -> writes 0x24080005@0x0 and 0x0000000C@0x4, then done=1, cpu_hold=0.
REQ-040 Same frame with mem_ack held 0 for 5 cycles on word 0 -> mem_we/addr/wdata stable for 6 cycles, byte_ready=0, exactly two writes total.
REQ-041 Same frame with checksum byte 0x26 -> both writes occur, then error=1, done=0, cpu_hold=1, byte_ready=0.
REQ-042 Header 0x41 with MAX_WORDS=64 -> ERR next edge, no mem_we pulse, error=1.
REQ-043 Header 00 then checksum 00 -> DONE with zero writes. Header 00 then checksum 01 -> ERR.
REQ-044 rst_n pulsed low during WRITE of word 1, then the full 2-word frame resent -> mem_we low during reset, final memory image matches REQ-039, done=1.
